// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    RUN  = 3'd5,
    ERR  = 3'd6
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_packer.sv
// Packs little-endian bytes into 32-bit words; word_done/word are combinational
// with the 4th accepted byte so the caller can register the write on that edge.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_done,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (byte_vld) begin
      // Shifting right keeps the first byte of a word in the low lane.
      sr  <= {byte_dat, sr[23:8]};
      cnt <= (cnt == LAST_IDX) ? 2'd0 : cnt + 2'd1;
    end
  end

  always_comb begin
    word_done = byte_vld && (cnt == LAST_IDX);
    word      = {byte_dat, sr};
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed UART byte image into instruction memory, then releases fetch.
// Optional BOOT_CHECKSUM_EN adds an XOR checksum byte after the data.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         DEPTH     = 1024,
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              boot_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              enable_pc,
  output logic              busy,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  boot_state_t state, state_nxt;
  logic [15:0] len;
  logic [15:0] len_full;
  logic        acc;
  logic        word_done;
  logic [31:0] word;
  logic        last_word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign acc       = rx_valid && rx_ready;
  assign len_full  = {rx_data, len[7:0]};
  assign last_word = (words_loaded + 16'd1) == len;

  boot_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (boot_req),
    .byte_vld  (acc && (state == DATA)),
    .byte_dat  (rx_data),
    .word_done (word_done),
    .word      (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (boot_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (acc && rx_data == SYNC_BYTE) state_nxt = LEN0;
        LEN0: if (acc) state_nxt = LEN1;
        LEN1: if (acc) begin
          if (len_full > DEPTH_W)
            state_nxt = ERR;
          else if (len_full == 16'd0)
`ifdef BOOT_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = RUN;
`endif
          else
            state_nxt = DATA;
        end
        DATA: if (word_done && last_word)
`ifdef BOOT_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = RUN;
`endif
`ifdef BOOT_CHECKSUM_EN
        CHK:  if (acc) state_nxt = (rx_data == csum) ? RUN : ERR;
`endif
        RUN:  state_nxt = RUN;
        ERR:  state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_ready  = !boot_req;
    enable_pc = (state == RUN);
    busy      = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
    load_err  = (state == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      len          <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum         <= '0;
`endif
    end else if (boot_req) begin
      imem_we      <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      // A new sync restarts per-frame bookkeeping.
      if (acc && state == IDLE && rx_data == SYNC_BYTE) begin
        words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (acc && state == LEN0) len[7:0]  <= rx_data;
      if (acc && state == LEN1) len[15:8] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
      if (acc && state == DATA) csum <= csum ^ rx_data;
`endif
      if (word_done) begin
        imem_we    <= 1'b1;
        imem_wdata <= WIDTH'(word);
        imem_waddr <= {words_loaded[ADDR_W-3:0], 2'b00};
        if (words_loaded < DEPTH_W) words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the fetch stage.
- Receives a program image as a byte stream from the UART receiver and packs it into 32-bit little-endian words.
- Writes those words into the instruction memory through its write port, and holds the PC (enable_pc=0) until the image is loaded.
- After a successful load, releases fetch; boot_req restarts the load at any time.

Parameters:
- WIDTH, 32, instruction/word width in bits (fixed 4 bytes/word)
- DEPTH, 1024, instruction memory depth in words
- ADDR_W, 12, byte-address width of imem_waddr (log2(DEPTH)+2)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer when rx_valid&&rx_ready
- boot_req  in  1  single-cycle pulse: abort and restart load
- imem_we  out  1  instruction memory write strobe
- imem_waddr  out  ADDR_W  byte address, word aligned ([1:0]=0)
- imem_wdata  out  WIDTH  word to write
- enable_pc  out  1  fetch PC enable; 1 only in RUN
- busy  out  1  1 in LEN0/LEN1/DATA/CHK
- load_err  out  1  1 in ERR
- words_loaded  out  16  words written so far in current frame

Behaviour:
- Reset (async, active-high): state=IDLE; rx_ready=1; imem_we=0; imem_waddr=0; imem_wdata=0; enable_pc=0; busy=0; load_err=0; words_loaded=0; byte/word counters=0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, 4*LEN data bytes (byte 0 = instr[7:0]), [CHK byte if checksum enabled].
- FSM states:
  - IDLE: accepts and drops any byte != SYNC_BYTE; on SYNC_BYTE -> LEN0.
  - LEN0: latch len[7:0] -> LEN1.
  - LEN1: latch len[15:8]. Then:
    - len > DEPTH -> ERR
    - len == 0 -> CHK (checksum enabled) or RUN (disabled)
    - otherwise -> DATA
  - DATA: shift bytes into 32-bit assembly register.
    - On the 4th byte of a word, at the next edge: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_waddr = word_idx<<2.
    - The same edge increments words_loaded.
    - After word LEN-1 is accepted -> CHK or RUN.
    - Write latency: 1 cycle after the accepting edge.
  - CHK: next byte compared with the running checksum; match -> RUN, mismatch -> ERR.
  - RUN: rx_ready=1; bytes are accepted and dropped; enable_pc=1 from the cycle after entry.
  - ERR: enable_pc=0, load_err=1; bytes are accepted and dropped.
- rx_ready=1 in every state except when boot_req=1 (then 0 that cycle).
- Only one byte is consumed per cycle. A byte accepted in the final state cycle belongs to that state.
- boot_req (any state, including mid-DATA or RUN):
  - Next edge: state=IDLE, counters and words_loaded cleared, enable_pc=0, load_err=0.
  - A partially assembled word is discarded; no imem_we is issued for it.
  - Wins over a simultaneous byte (rx_ready=0 that cycle, so the byte is not consumed).
- imem_we is never asserted outside DATA completion. imem_waddr and imem_wdata hold their last values when imem_we=0.
- Reset mid-load: same as the reset values above; the memory contents are undefined for the partial image.
- words_loaded saturates at DEPTH (unreachable by construction).

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined: 8-bit XOR of all 4*LEN data bytes; CHK state present; mismatch -> ERR.
- Undefined: no CHK state; the last data word (or LEN==0) goes straight to RUN; ERR is reachable only via the length check.

Decomposition:
- Shared package boot_pkg holds:
  - boot_state_t enum (IDLE, LEN0, LEN1, DATA, CHK, RUN, ERR)
  - SYNC_BYTE default
  - BYTES_PER_WORD=4
- One sub-module, boot_word_packer: byte shift register plus 2-bit byte counter, output word_done pulse and word. It is cleared by boot_req or reset.
- The FSM, address counter and checksum stay in the top module.

Test Plan:
- Send A5,02,00,13,00,00,00,93,00,10,00 (+CHK=0x90 if enabled) -> imem_we pulses twice: addr 0x000 data 0x00000013, addr 0x004 data 0x00100093; words_loaded=2; enable_pc=1 afterwards.
- Send 00,FF,A5,01,00,EF,BE,AD,DE -> leading bytes dropped; one write, addr 0x000 data 0xDEADBEEF; RUN (CHK byte 0x22 when enabled).
- Send A5,01,04 (len=1025 > DEPTH) -> ERR, load_err=1, enable_pc=0, no imem_we.
- BOOT_CHECKSUM_EN defined: frame with one word 0x00000013 and CHK=0x00 -> ERR. With CHK=0x13 -> RUN.
- boot_req after 2 of 4 bytes of word 1 -> no write for that word; words_loaded=0; state IDLE; a new frame loads correctly from addr 0.
- Send A5,00,00 (+CHK=00 if enabled) -> no writes; enable_pc=1 on the cycle after RUN entry.
